// File: rtl/ota_sar_ctrl.sv
// ota_sar_ctrl: successive-approximation controller closing the loop around an OTA comparator and an external R-2R DAC.
//   clk_i       system clock
//   rst_n_i     asynchronous active-low reset
//   start_i     request a conversion (honoured only when idle)
//   abort_i     synchronous cancel of a running conversion
//   cmp_in_i    asynchronous comparator output, 1 = analog input >= DAC level
//   dac_code_o  trial code driven to the DAC
//   busy_o      conversion in progress
//   done_o      one-cycle pulse when result_o is updated
//   result_o    last completed conversion
module ota_sar_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             cmp_in_i,
    output logic [WIDTH-1:0] dac_code_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int PW = $clog2(WIDTH);
    localparam int CW = $clog2(SETTLE_CYCLES);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] DECIDE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;
    localparam logic [WIDTH-1:0] MSB      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [PW-1:0]    PTR_TOP  = PW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    // The decision must see a comparator level captured after the DAC settled.
    if (SETTLE_CYCLES < SYNC_STAGES + 1) begin : g_cfg_check
        $error("ota_sar_ctrl: SETTLE_CYCLES must be >= SYNC_STAGES+1");
    end

    logic [1:0]             state_q, state_d;
    logic [WIDTH-1:0]       dac_q, dac_d, res_q, res_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   busy_q, done_q;
    logic                   cmp_s;

    assign cmp_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        dac_d   = dac_q;
        res_d   = res_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // abort has priority over a simultaneous start
                if (start_i && !abort_i) begin
                    state_d = SETTLE;
                    dac_d   = MSB;
                    ptr_d   = PTR_TOP;
                    cnt_d   = CNT_LOAD;
                end
            end
            SETTLE: begin
                if (abort_i) begin
                    state_d = IDLE;
                    dac_d   = res_q;
                end else if (cnt_q == '0) begin
                    state_d = DECIDE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DECIDE: begin
                if (abort_i) begin
                    state_d = IDLE;
                    dac_d   = res_q;
                end else begin
                    dac_d[ptr_q] = cmp_s;
                    if (ptr_q != '0) begin
                        dac_d[ptr_q - 1'b1] = 1'b1;
                        ptr_d   = ptr_q - 1'b1;
                        cnt_d   = CNT_LOAD;
                        state_d = SETTLE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                res_d   = dac_q;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            dac_q   <= '0;
            res_q   <= '0;
            ptr_q   <= PTR_TOP;
            cnt_q   <= '0;
            sync_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dac_q   <= dac_d;
            res_q   <= res_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], cmp_in_i};
            busy_q  <= (state_d == SETTLE) || (state_d == DECIDE);
            done_q  <= state_q == DONE;
        end
    end

    assign dac_code_o = dac_q;
    assign result_o   = res_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
endmodule

// File: tb/tb_ota_sar_ctrl.sv
// tb_ota_sar_ctrl: directed scoreboard bench for ota_sar_ctrl (default instance plus a SETTLE_CYCLES=3 instance).
module tb_ota_sar_ctrl;
    typedef struct packed {
        logic [7:0] res;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, cmp;
    logic [7:0] dac, res;
    logic       busy, done;
    logic       start3, abort3, cmp3;
    logic [7:0] dac3, res3;
    logic       busy3, done3;
    int         mode;
    logic [7:0] target;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    exp_t       q[$];
    exp_t       q3[$];
    exp_t       e, e3;

    ota_sar_ctrl dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort), .cmp_in_i(cmp),
        .dac_code_o(dac), .busy_o(busy), .done_o(done), .result_o(res)
    );

    ota_sar_ctrl #(.WIDTH(8), .SETTLE_CYCLES(3), .SYNC_STAGES(2)) dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start3), .abort_i(abort3), .cmp_in_i(cmp3),
        .dac_code_o(dac3), .busy_o(busy3), .done_o(done3), .result_o(res3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mode 0: ideal comparator against target, 1: tied high, 2: tied low
    always_comb cmp = (mode == 0) ? (target >= dac) : (mode == 1);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got result 0x%0h expected no done (cycle %0d)", res, cyc);
            end else begin
                e = q.pop_front();
                chk("done_result", res, e.res);
                chk("done_cycle", cyc, e.cyc);
            end
        end
        if (done3) begin
            if (q3.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done3: got result 0x%0h expected no done (cycle %0d)", res3, cyc);
            end else begin
                e3 = q3.pop_front();
                chk("done3_result", res3, e3.res);
                chk("done3_cycle", cyc, e3.cyc);
            end
        end
    end

    // Called on a negedge; returns on the negedge after the sampling edge.
    task automatic start_conv(input logic [7:0] exp_res, input bit push);
        start = 1'b1;
        if (push) q.push_back('{res: exp_res, cyc: cyc + 42});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_track(input logic [7:0] exp_res, input logic [63:0] seq);
        start_conv(exp_res, 1'b1);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 5; j++) begin
                if (j == 0) begin
                    chk("trial_first", dac, seq[63-8*i -: 8]);
                    chk("busy_in_conv", busy, 1);
                end
                if (j == 4) chk("trial_last", dac, seq[63-8*i -: 8]);
                @(negedge clk);
            end
        end
        repeat (2) @(negedge clk);
        chk("idle_dac_holds_result", dac, exp_res);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1; target = 8'h00;
        start3 = 1'b0; abort3 = 1'b0; cmp3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dac", dac, 0);
        chk("rst_result", res, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dac3", dac3, 0);

        // full scale high, started on the first edge after reset release
        rst_n = 1'b1;
        run_track(8'hFF, 64'h80C0E0F0F8FCFEFF);
        // tracking an 0xA5 input
        mode = 0; target = 8'hA5;
        run_track(8'hA5, 64'h80C0A0B0A8A4A6A5);
        // full scale low
        mode = 2;
        run_track(8'h00, 64'h8040201008040201);

        // asynchronous reset mid-conversion, mid-clock
        mode = 0; target = 8'h81;
        run_track(8'h81, 64'h80C0A09088848281);
        start_conv(8'h00, 1'b0);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("amid_rst_dac", dac, 0);
        chk("amid_rst_result", res, 0);
        chk("amid_rst_busy", busy, 0);
        chk("amid_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        target = 8'h5A;
        start_conv(8'h5A, 1'b1);
        chk("post_rst_first_trial", dac, 8'h80);
        chk("post_rst_busy", busy, 1);

        // starts at cycles 10 and 40 of a running conversion are ignored
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("ignored_start_busy", busy, 0);
        chk("ignored_start_result", res, 8'h5A);

        // start held high: done pulses 42 cycles apart
        target = 8'h33;
        start = 1'b1;
        q.push_back('{res: 8'h33, cyc: cyc + 42});
        q.push_back('{res: 8'h33, cyc: cyc + 84});
        repeat (50) @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("held_start_idle", busy, 0);

        // abort during the 4th bit's SETTLE
        target = 8'h3C;
        start_conv(8'h3C, 1'b1);
        repeat (43) @(negedge clk);
        target = 8'hC3;
        start_conv(8'h00, 1'b0);
        repeat (16) @(negedge clk);
        chk("pre_abort_trial", dac, 8'hD0);
        chk("pre_abort_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_dac", dac, 8'h3C);
        chk("abort_result", res, 8'h3C);
        chk("abort_done", done, 0);
        repeat (45) @(negedge clk);
        chk("abort_result_kept", res, 8'h3C);
        start_conv(8'hC3, 1'b1);
        repeat (43) @(negedge clk);

        // abort and start together in IDLE: no conversion
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", busy, 0);
        chk("abort_start_dac", dac, 8'hC3);
        repeat (45) @(negedge clk);

        // synchronizer/settle: glitch early in each window, hold the true level for the last 3 cycles
        target = 8'h6D;
        start3 = 1'b1;
        q3.push_back('{res: 8'h6D, cyc: cyc + 34});
        @(negedge clk);
        start3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1 cmp3 = ~target[7-i];
            #1 cmp3 = target[7-i];
            #1 cmp3 = ~target[7-i];
            @(posedge clk);
            #1 cmp3 = target[7-i];
            repeat (3) @(posedge clk);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("sync_busy3", busy3, 0);

        chk("queues_drained", q.size() + q3.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ota_sar_ctrl.md
Name: ota_sar_ctrl

Overview:
Digital back end that reads the inverter-based OTA/comparator output and closes the loop as a successive-approximation ADC. Each cycle it drives a trial code to an external R-2R DAC feeding the OTA reference input. It then samples the OTA decision through a synchronizer and resolves one bit per step, MSB first. It sits between the analog OTA macro (cmp_in) and the tile's dedicated I/O (dac_code, result).

Parameters:
WIDTH, 8, conversion resolution in bits (2..12)
SETTLE_CYCLES, 4, clocks the DAC/OTA settle per bit before the decision; must be >= SYNC_STAGES+1 (simulation assertion)
SYNC_STAGES, 2, flip-flops in the cmp_in synchronizer (>= 2)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request a conversion; sampled only in IDLE
abort  input  1  synchronous cancel of a running conversion
cmp_in  input  1  asynchronous OTA output; 1 = analog input >= DAC level
dac_code  output  WIDTH  trial code to the external DAC
busy  output  1  conversion in progress
done  output  1  one-cycle pulse when result is updated
result  output  WIDTH  last completed conversion; holds until the next done

Behaviour:
- Reset (rst_n low, async): state=IDLE; dac_code=0, result=0, busy=0, done=0, synchronizer flops=0, bit pointer=MSB, settle counter=0.
- Reset takes effect mid-conversion immediately. The first valid start is accepted on the first clk edge after rst_n rises.
- cmp_in passes through SYNC_STAGES flops. Only the synchronized value (cmp_s) is used.
- States:
  - IDLE: busy=0. dac_code holds the last result.
  - On start=1, go to SETTLE. Set dac_code = 1<<(WIDTH-1), bit pointer = WIDTH-1, counter = SETTLE_CYCLES-1.
  - SETTLE: busy=1. Decrement the counter each cycle. When the counter is 0, go to DECIDE.
  - DECIDE (1 cycle): busy=1. If cmp_s=1, keep bit[ptr]; else clear it.
    - If ptr>0: set bit[ptr-1], decrement ptr, reload counter = SETTLE_CYCLES-1, go to SETTLE.
    - If ptr=0: go to DONE.
  - DONE (1 cycle): result <= dac_code, done=1, busy=0. Next state is IDLE.
- Per-bit cost is SETTLE_CYCLES+1 clocks.
- Latency: the start-sampling edge is cycle 0. done is high during cycle WIDTH*(SETTLE_CYCLES+1)+1, which is 41 for the defaults.
- Lower bits beyond the current trial bit are always 0 in dac_code.
- start while not in IDLE is ignored (no queueing).
- start held high gives back-to-back conversions separated by exactly one IDLE cycle.
- abort=1 in SETTLE or DECIDE: IDLE on the next edge. dac_code <= result, busy=0, no done, result unchanged.
- abort in IDLE or DONE has no effect; DONE completes normally.
- abort and start both high in IDLE: abort wins and no conversion starts.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset behaviour: assert rst_n=0 asynchronously, mid-clock, during a conversion -> all outputs 0 immediately. Release, pulse start -> dac_code=0x80 on the next cycle.
2. Tracking: bench comparator cmp_in = (0xA5 >= dac_code), defaults, pulse start.
   - dac_code trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5, each held 5 cycles.
   - done high 41 cycles after start; result=0xA5.
3. Full scale: cmp_in tied 1 -> result=0xFF. cmp_in tied 0 -> result=0x00. Each completes in 41 cycles.
4. Handshake: pulse start again at cycles 10 and 40 -> ignored, one done only. Hold start high -> done pulses exactly 42 cycles apart.
5. Abort: complete a conversion to 0x3C, start another, assert abort during the 4th bit's SETTLE.
   - Next cycle: busy=0, dac_code=0x3C, result stays 0x3C, no done.
   - A new start converts normally.
6. Synchronizer/settle: toggle cmp_in asynchronously except in the final 3 cycles of each SETTLE window, with the expected level held there. Run with SETTLE_CYCLES=3, SYNC_STAGES=2 -> each bit matches the held level; result correct.
